risc_prog_loader: RTL

Boot-time program loader for the accumulator RISC CPU. Accepts a length-prefixed, checksummed byte stream on a valid/ready interface and writes it into the CPU's 32×8 program/data memory, starting at address 0. It holds the CPU in reset until a complete, verified image is in memory, then releases it. It sits between an external host link (UART bridge or test harness) and the memory write port. It replaces backdoor memory preloading as the way programs get into memory.

---
 rtl/risc_pkg.sv | 34 +++
 rtl/risc_prog_loader.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/risc_pkg.sv
// -----------------------------------------------------------------------------
// risc_pkg
// Definitions shared by the accumulator RISC CPU top and its boot-time program
// loader:
//   - loader_state_t : the loader's state encoding (IDLE, LEN, DATA, CSUM, RUN, ERR)
//   - MEM_DEPTH      : number of words in the program/data memory (32)
//   - MAX_LEN        : largest image length the loader accepts (32)
//   - CPU_RST_ACTIVE : level that holds the CPU in reset (active-high)
//   - len_legal()    : decides whether a length byte describes a loadable image
// -----------------------------------------------------------------------------
package risc_pkg;

  localparam int MEM_DEPTH = 32;
  localparam int MAX_LEN   = 32;

  // The CPU's rst input is active-high; the loader drives this level while
  // it owns the memory write port.
  localparam logic CPU_RST_ACTIVE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_CSUM = 3'd3,
    ST_RUN  = 3'd4,
    ST_ERR  = 3'd5
  } loader_state_t;

  // An image must hold at least one byte and must fit in memory.
  function automatic logic len_legal(input int len);
    return (len >= 1) && (len <= MAX_LEN) && (len <= MEM_DEPTH);
  endfunction

endpackage

// File: rtl/risc_prog_loader.sv
// -----------------------------------------------------------------------------
// risc_prog_loader
// Boot-time program loader for the accumulator RISC CPU. Receives a
// length-prefixed byte stream over a valid/ready link, writes the data bytes
// into program memory from address 0 upward and keeps the CPU in reset until a
// complete image has been written (and, when enabled, its checksum verified).
//
// Stream: LEN (1..32), LEN data bytes, then CSUM (sum of data mod 256) when the
// checksum is compiled in.
//
// Build option:
//   RISC_LOADER_CSUM_EN  defined   -> CSUM byte expected and verified
//                        undefined -> last data byte goes straight to RUN
//
// Ports:
//   clk       in   single clock, rising edge
//   rst       in   synchronous reset, active-low
//   start     in   one-cycle pulse that begins or restarts a load
//   s_valid   in   host byte valid
//   s_data    in   host byte
//   s_ready   out  loader accepts a byte this cycle (independent of s_valid)
//   mem_wr    out  registered write strobe, one cycle per data byte
//   mem_addr  out  registered write address
//   mem_data  out  registered write data
//   cpu_rst   out  CPU reset, active-high; low only once an image is running
//   done      out  image loaded and CPU released
//   err       out  load failed; sticky until the next start
// -----------------------------------------------------------------------------
module risc_prog_loader
  import risc_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  // One extra bit so a full-memory length (2^ADDR_W) fits in the down-counter.
  localparam int REM_W = ADDR_W + 1;

  loader_state_t     r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [REM_W-1:0]  r_remaining;
`ifdef RISC_LOADER_CSUM_EN
  logic [DATA_W-1:0] r_sum;
`endif

  logic              r_mem_wr;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_data;
  logic              r_cpu_rst;
  logic              r_done;
  logic              r_err;

  logic w_loading;
  logic w_hs;
  logic w_last;

  // Only the three stream-consuming states accept bytes, and a start pulse
  // always wins over a coincident byte so that byte is left for the host.
  assign w_loading = (r_state == ST_LEN) || (r_state == ST_DATA) || (r_state == ST_CSUM);
  assign s_ready   = w_loading & ~start;
  assign w_hs      = s_valid & s_ready;
  assign w_last    = (r_remaining == REM_W'(1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
`ifdef RISC_LOADER_CSUM_EN
      r_sum       <= '0;
`endif
      r_mem_wr    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_data  <= '0;
      r_cpu_rst   <= CPU_RST_ACTIVE;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      // Strobe is a single-cycle pulse per accepted data byte.
      r_mem_wr <= 1'b0;

      if (start) begin
        // Restart from any state. Memory contents are deliberately left alone.
        r_state   <= ST_LEN;
        r_addr    <= '0;
`ifdef RISC_LOADER_CSUM_EN
        r_sum     <= '0;
`endif
        r_cpu_rst <= CPU_RST_ACTIVE;
        r_done    <= 1'b0;
        r_err     <= 1'b0;
      end else if (w_hs) begin
        case (r_state)
          ST_LEN: begin
            if (len_legal(int'(s_data))) begin
              r_remaining <= REM_W'(s_data);
              r_addr      <= '0;
`ifdef RISC_LOADER_CSUM_EN
              r_sum       <= '0;
`endif
              r_state     <= ST_DATA;
            end else begin
              r_state <= ST_ERR;
              r_err   <= 1'b1;
            end
          end

          ST_DATA: begin
            r_mem_wr    <= 1'b1;
            r_mem_addr  <= r_addr;
            r_mem_data  <= s_data;
            // After the 32nd byte the address wraps to 0 internally; the state
            // leaves DATA at the same edge, so no write ever uses it.
            r_addr      <= r_addr + ADDR_W'(1);
            r_remaining <= r_remaining - REM_W'(1);
`ifdef RISC_LOADER_CSUM_EN
            r_sum       <= r_sum + s_data;
            if (w_last) begin
              r_state <= ST_CSUM;
            end
`else
            if (w_last) begin
              r_state   <= ST_RUN;
              r_cpu_rst <= ~CPU_RST_ACTIVE;
              r_done    <= 1'b1;
            end
`endif
          end

`ifdef RISC_LOADER_CSUM_EN
          ST_CSUM: begin
            if (s_data == r_sum) begin
              r_state   <= ST_RUN;
              r_cpu_rst <= ~CPU_RST_ACTIVE;
              r_done    <= 1'b1;
            end else begin
              r_state <= ST_ERR;
              r_err   <= 1'b1;
            end
          end
`endif

          default: begin
            // IDLE, RUN and ERR never see a handshake (s_ready is low).
          end
        endcase
      end
    end
  end

  assign mem_wr   = r_mem_wr;
  assign mem_addr = r_mem_addr;
  assign mem_data = r_mem_data;
  assign cpu_rst  = r_cpu_rst;
  assign done     = r_done;
  assign err      = r_err;

endmodule
